// File: rtl/frame_scan_sequencer.sv
// Window scan sequencer: walks the sensor row/col pointers over a window and
// hands each pixel to the ADC controller. Pointer pulses are P cycles high, then P low.
module frame_scan_sequencer #(
    parameter int MAX_RESOLUTION = 112,
    parameter int PULSE_CYCLES   = 4,
    parameter int DONE_TIMEOUT   = 1023
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_start,
    input  logic       abort,
    input  logic [7:0] win_row0,
    input  logic [7:0] win_col0,
    input  logic [7:0] win_rows,
    input  logic [7:0] win_cols,
    input  logic [7:0] settle_counts,
    input  logic       adc_capture_done,
    output logic       adc_capture_start,
    output logic       row_rst,
    output logic       row_inc,
    output logic       col_rst,
    output logic       col_inc,
    output logic       newline_sample,
    output logic [7:0] row_index,
    output logic [7:0] col_index,
    output logic       busy,
    output logic       frame_done,
    output logic       cfg_error,
    output logic       capture_timeout
);

    typedef enum logic [3:0] {
        IDLE, ROW_RST, ROW_SEEK, COL_RST, COL_SEEK,
        SETTLE, CAPTURE, WAIT_DONE, NEXT
    } state_t;

    localparam logic [15:0] P_HI   = 16'(PULSE_CYCLES);
    localparam logic [15:0] P_END  = 16'(2 * PULSE_CYCLES - 1);
    localparam logic [15:0] TO_END = 16'(DONE_TIMEOUT - 1);

    state_t      state, state_nxt, settle_state;
    logic [15:0] tmr;
    logic        tmr_clr;
    logic [7:0]  cnt, cnt_nxt;
    logic [7:0]  row_nxt, col_nxt;
    logic [7:0]  row0_q, col0_q, rows_q, cols_q, settle_q;
    logic        cfg_err_nxt, timeout_nxt;
    logic        pulse_hi, pulse_end, last_col, last_row, cfg_bad;
    logic [8:0]  row_end, col_end;

    assign row_end = {1'b0, win_row0} + {1'b0, win_rows};
    assign col_end = {1'b0, win_col0} + {1'b0, win_cols};
    assign cfg_bad = (win_rows == 8'd0) || (win_cols == 8'd0) ||
                     (row_end > 9'(MAX_RESOLUTION)) ||
                     (col_end > 9'(MAX_RESOLUTION));

    assign pulse_hi     = tmr < P_HI;
    assign pulse_end    = tmr == P_END;
    assign last_col     = col_index == cols_q - 8'd1;
    assign last_row     = row_index == rows_q - 8'd1;
    // A zero settle time skips SETTLE and requests the capture directly.
    assign settle_state = (settle_q == 8'd0) ? CAPTURE : SETTLE;
    assign busy         = state != IDLE;

    always_comb begin
        state_nxt         = state;
        cnt_nxt           = cnt;
        row_nxt           = row_index;
        col_nxt           = col_index;
        tmr_clr           = 1'b0;
        cfg_err_nxt       = 1'b0;
        timeout_nxt       = 1'b0;
        adc_capture_start = 1'b0;
        row_rst           = 1'b0;
        row_inc           = 1'b0;
        col_rst           = 1'b0;
        col_inc           = 1'b0;
        newline_sample    = 1'b0;
        frame_done        = 1'b0;
        case (state)
            IDLE: begin
                if (frame_start) begin
                    if (cfg_bad) begin
                        cfg_err_nxt = 1'b1;
                    end else begin
                        state_nxt = ROW_RST;
                        row_nxt   = 8'd0;
                        col_nxt   = 8'd0;
                        cnt_nxt   = 8'd0;
                    end
                end
            end
            ROW_RST: begin
                row_rst = pulse_hi;
                if (pulse_end) begin
                    state_nxt = (row0_q != 8'd0) ? ROW_SEEK : COL_RST;
                    cnt_nxt   = 8'd0;
                end
            end
            ROW_SEEK: begin
                row_inc = pulse_hi;
                if (pulse_end) begin
                    tmr_clr = 1'b1;
                    if (cnt == row0_q - 8'd1) begin
                        state_nxt = COL_RST;
                        cnt_nxt   = 8'd0;
                    end else begin
                        cnt_nxt = cnt + 8'd1;
                    end
                end
            end
            COL_RST: begin
                col_rst = pulse_hi;
                if (pulse_end) begin
                    state_nxt = (col0_q != 8'd0) ? COL_SEEK : settle_state;
                    cnt_nxt   = 8'd0;
                end
            end
            COL_SEEK: begin
                col_inc = pulse_hi;
                if (pulse_end) begin
                    tmr_clr = 1'b1;
                    if (cnt == col0_q - 8'd1) begin
                        state_nxt = settle_state;
                        cnt_nxt   = 8'd0;
                    end else begin
                        cnt_nxt = cnt + 8'd1;
                    end
                end
            end
            SETTLE: begin
                newline_sample = (tmr == 16'd0) && (col_index == 8'd0);
                if (tmr == 16'(settle_q) - 16'd1) state_nxt = CAPTURE;
            end
            CAPTURE: begin
                adc_capture_start = 1'b1;
                newline_sample    = (settle_q == 8'd0) && (col_index == 8'd0);
                state_nxt         = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (adc_capture_done) begin
                    state_nxt = NEXT;
                end else if (tmr == TO_END) begin
                    state_nxt   = IDLE;
                    timeout_nxt = 1'b1;
                end
            end
            NEXT: begin
                if (last_col && last_row) begin
                    frame_done = 1'b1;
                    state_nxt  = IDLE;
                end else if (!last_col) begin
                    col_inc = pulse_hi;
                    if (pulse_end) begin
                        col_nxt   = col_index + 8'd1;
                        state_nxt = settle_state;
                    end
                end else begin
                    row_inc = pulse_hi;
                    if (pulse_end) begin
                        row_nxt   = row_index + 8'd1;
                        col_nxt   = 8'd0;
                        state_nxt = COL_RST;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
        // Abort wins over every transition and silences the pulse outputs.
        if (abort && state != IDLE) begin
            state_nxt         = IDLE;
            timeout_nxt       = 1'b0;
            adc_capture_start = 1'b0;
            row_rst           = 1'b0;
            row_inc           = 1'b0;
            col_rst           = 1'b0;
            col_inc           = 1'b0;
            newline_sample    = 1'b0;
            frame_done        = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            tmr             <= 16'd0;
            cnt             <= 8'd0;
            row_index       <= 8'd0;
            col_index       <= 8'd0;
            row0_q          <= 8'd0;
            col0_q          <= 8'd0;
            rows_q          <= 8'd0;
            cols_q          <= 8'd0;
            settle_q        <= 8'd0;
            cfg_error       <= 1'b0;
            capture_timeout <= 1'b0;
        end else begin
            state           <= state_nxt;
            tmr             <= (tmr_clr || state_nxt != state) ? 16'd0 : tmr + 16'd1;
            cnt             <= cnt_nxt;
            row_index       <= row_nxt;
            col_index       <= col_nxt;
            cfg_error       <= cfg_err_nxt;
            capture_timeout <= timeout_nxt;
            if (state == IDLE && frame_start) begin
                row0_q   <= win_row0;
                col0_q   <= win_col0;
                rows_q   <= win_rows;
                cols_q   <= win_cols;
                settle_q <= settle_counts;
            end
        end
    end

endmodule

// File: tb/tb_frame_scan_sequencer.sv
// Directed bench for frame_scan_sequencer: pulse counts, timing boundaries,
// config errors, timeout, abort and reset behaviour.
module tb_frame_scan_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       frame_start = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] win_row0 = '0, win_col0 = '0, win_rows = '0, win_cols = '0;
    logic [7:0] settle_counts = '0;
    logic       adc_capture_done = 1'b0;
    logic       adc_capture_start, row_rst, row_inc, col_rst, col_inc;
    logic       newline_sample, busy, frame_done, cfg_error, capture_timeout;
    logic [7:0] row_index, col_index;
    logic [9:0] outs;

    always #5 clk = ~clk;

    frame_scan_sequencer dut (
        .clk(clk), .reset(reset), .frame_start(frame_start), .abort(abort),
        .win_row0(win_row0), .win_col0(win_col0),
        .win_rows(win_rows), .win_cols(win_cols),
        .settle_counts(settle_counts), .adc_capture_done(adc_capture_done),
        .adc_capture_start(adc_capture_start), .row_rst(row_rst),
        .row_inc(row_inc), .col_rst(col_rst), .col_inc(col_inc),
        .newline_sample(newline_sample), .row_index(row_index),
        .col_index(col_index), .busy(busy), .frame_done(frame_done),
        .cfg_error(cfg_error), .capture_timeout(capture_timeout)
    );

    assign outs = {adc_capture_start, row_rst, row_inc, col_rst, col_inc,
                   newline_sample, busy, frame_done, cfg_error, capture_timeout};

    int tests = 0, fails = 0;
    int c_rr = 0, c_ri = 0, c_cr = 0, c_ci = 0, c_st = 0, c_nl = 0;
    int c_fd = 0, c_ce = 0, c_to = 0, c_oh = 0, cap_sum = 0;
    int resp_cnt = 0, resp_delay = 20;
    bit resp_en = 1'b1;

    // High-cycle counters sampled mid-cycle.
    always @(negedge clk) begin
        c_rr += int'(row_rst);
        c_ri += int'(row_inc);
        c_cr += int'(col_rst);
        c_ci += int'(col_inc);
        c_st += int'(adc_capture_start);
        c_nl += int'(newline_sample);
        c_fd += int'(frame_done);
        c_ce += int'(cfg_error);
        c_to += int'(capture_timeout);
        if (adc_capture_start)
            cap_sum += int'(row_index) * 16 + int'(col_index) + 1;
        if (int'(row_rst) + int'(row_inc) + int'(col_rst) + int'(col_inc) > 1)
            c_oh++;
    end

    // ADC model: done pulse resp_delay cycles after each capture request.
    always @(negedge clk) begin
        adc_capture_done = 1'b0;
        if (resp_cnt != 0) begin
            resp_cnt--;
            if (resp_cnt == 0) adc_capture_done = 1'b1;
        end
        if (adc_capture_start && resp_en) resp_cnt = resp_delay;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int k = 0;
        while (busy && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk(tag, int'(busy), 0);
    endtask

    task automatic start_frame(input int r0, input int c0, input int rs,
                               input int cs, input int st);
        win_row0      = 8'(r0);
        win_col0      = 8'(c0);
        win_rows      = 8'(rs);
        win_cols      = 8'(cs);
        settle_counts = 8'(st);
        frame_start   = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    int b_rr, b_ri, b_cr, b_ci, b_st, b_nl, b_fd, b_ce, b_to, b_cs, b_ptr;

    task automatic snap();
        b_rr = c_rr; b_ri = c_ri; b_cr = c_cr; b_ci = c_ci; b_st = c_st;
        b_nl = c_nl; b_fd = c_fd; b_ce = c_ce; b_to = c_to; b_cs = cap_sum;
        b_ptr = c_rr + c_ri + c_cr + c_ci;
    endtask

    initial begin
        // Reset state
        cyc(3);
        chk("rst_outs", int'(outs), 0);
        chk("rst_row", int'(row_index), 0);
        chk("rst_col", int'(col_index), 0);
        reset = 1'b0;
        cyc(1);

        // 2x2 window at (2,3), settle 5, done after 20; extra request ignored
        snap();
        resp_en = 1'b1;
        resp_delay = 20;
        start_frame(2, 3, 2, 2, 5);
        chk("a_busy", int'(busy), 1);
        cyc(30);
        start_frame(0, 0, 1, 1, 0);
        wait_idle("a_idle", 3000);
        cyc(2);
        chk("a_row_rst", c_rr - b_rr, 1 * 4);
        chk("a_row_inc", c_ri - b_ri, 3 * 4);
        chk("a_col_rst", c_cr - b_cr, 2 * 4);
        chk("a_col_inc", c_ci - b_ci, 8 * 4);
        chk("a_start", c_st - b_st, 4);
        chk("a_newline", c_nl - b_nl, 2);
        chk("a_done", c_fd - b_fd, 1);
        chk("a_coords", cap_sum - b_cs, 1 + 2 + 17 + 18);
        chk("a_cfgerr", c_ce - b_ce, 0);
        chk("a_onehot", c_oh, 0);

        // Invalid configs
        snap();
        start_frame(0, 0, 4, 0, 1);
        chk("b_cfgerr", int'(cfg_error), 1);
        chk("b_busy", int'(busy), 0);
        cyc(1);
        chk("b_cfgerr_clr", int'(cfg_error), 0);
        start_frame(0, 100, 1, 20, 1);
        chk("c_cfgerr", int'(cfg_error), 1);
        chk("c_busy", int'(busy), 0);
        cyc(3);
        chk("bc_ptr", c_rr + c_ri + c_cr + c_ci - b_ptr, 0);

        // Exactly at the limit is valid
        start_frame(0, 100, 1, 12, 1);
        chk("lim_busy", int'(busy), 1);
        chk("lim_cfgerr", int'(cfg_error), 0);
        abort = 1'b1;
        cyc(1);
        abort = 1'b0;
        chk("lim_abort", int'(busy), 0);

        // 1x1 at origin, settle 0: capture right after the col_rst low phase
        snap();
        resp_delay = 3;
        start_frame(0, 0, 1, 1, 0);
        chk("d_rr_c1", int'(row_rst), 1);
        cyc(8);
        chk("d_cr_c9", int'(col_rst), 1);
        cyc(7);
        chk("d_st_c16", int'(adc_capture_start), 0);
        cyc(1);
        chk("d_st_c17", int'(adc_capture_start), 1);
        chk("d_nl_c17", int'(newline_sample), 1);
        wait_idle("d_idle", 200);
        cyc(1);
        chk("d_done", c_fd - b_fd, 1);

        // Withheld done: timeout 1023 cycles after WAIT_DONE entry
        snap();
        resp_en = 1'b0;
        start_frame(0, 0, 1, 1, 0);
        cyc(1039);
        chk("e_to_early", int'(capture_timeout), 0);
        chk("e_busy_early", int'(busy), 1);
        cyc(1);
        chk("e_to", int'(capture_timeout), 1);
        chk("e_busy", int'(busy), 0);
        cyc(2);
        chk("e_done", c_fd - b_fd, 0);
        chk("e_to_cnt", c_to - b_to, 1);
        resp_en = 1'b1;

        // Abort during a col_inc high phase, then a fresh scan
        snap();
        start_frame(0, 2, 1, 1, 3);
        cyc(17);
        chk("f_ci_high", int'(col_inc), 1);
        abort = 1'b1;
        cyc(1);
        abort = 1'b0;
        chk("f_ci_low", int'(col_inc), 0);
        chk("f_busy", int'(busy), 0);
        cyc(20);
        chk("f_done", c_fd - b_fd, 0);
        start_frame(1, 1, 1, 1, 0);
        chk("f_restart_rr", int'(row_rst), 1);
        chk("f_restart_row", int'(row_index), 0);
        wait_idle("f_idle", 500);

        // Reset mid-frame, with a coincident frame_start
        snap();
        start_frame(2, 3, 2, 2, 5);
        cyc(12);
        reset = 1'b1;
        frame_start = 1'b1;
        cyc(1);
        chk("g_outs", int'(outs), 0);
        chk("g_row", int'(row_index), 0);
        chk("g_col", int'(col_index), 0);
        reset = 1'b0;
        frame_start = 1'b0;
        cyc(1);
        chk("g_busy", int'(busy), 0);
        cyc(10);
        chk("g_done", c_fd - b_fd, 0);
        chk("g_onehot", c_oh, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/frame_scan_sequencer.md
FRAME_SCAN_SEQUENCER -- requirements
Module: frame_scan_sequencer

Interface
REQ-001 Parameter MAX_RESOLUTION, default 112: sensor rows and columns.
REQ-002 Parameter PULSE_CYCLES, default 4: high time, and following low time, of each pointer pulse in clk cycles.
REQ-003 Parameter DONE_TIMEOUT, default 1023: maximum cycles spent waiting for adc_capture_done.
REQ-004 clk  in  1  clock; all state updates on rising edge.
REQ-005 reset  in  1  reset, synchronous, active-high.
REQ-006 frame_start  in  1  single-cycle request to scan one window.
REQ-007 abort  in  1  terminates the scan in progress.
REQ-008 win_row0, win_col0  in  8 each  window origin.
REQ-009 win_rows, win_cols  in  8 each  window size.
REQ-010 settle_counts  in  8  cycles from pointer settle to capture request.
REQ-011 adc_capture_done  in  1  single-cycle pulse from ADC controller, track phase complete.
REQ-012 adc_capture_start  out  1  single-cycle capture request to ADC controller.
REQ-013 row_rst, row_inc, col_rst, col_inc  out  1 each  sensor pointer pulses.
REQ-014 newline_sample  out  1  single-cycle marker before the first capture of each row.
REQ-015 row_index, col_index  out  8 each  window-relative coordinate of the pixel being captured.
REQ-016 busy  out  1  high whenever state is not IDLE.
REQ-017 frame_done, cfg_error, capture_timeout  out  1 each  single-cycle status pulses.

Function
REQ-018 States: IDLE, ROW_RST, ROW_SEEK, COL_RST, COL_SEEK, SETTLE, CAPTURE, WAIT_DONE, NEXT.
REQ-019 IDLE plus frame_start: latch all win_* and settle_counts; config inputs are ignored until the next IDLE.
REQ-020 Invalid config is win_rows==0, win_cols==0, win_row0+win_rows>MAX_RESOLUTION, or win_col0+win_cols>MAX_RESOLUTION, using 9-bit sums; on invalid config cfg_error pulses the next cycle and the block stays IDLE.
REQ-021 Every pointer pulse is high for PULSE_CYCLES, then low for PULSE_CYCLES, before the next action; only one pointer output is high at a time.
REQ-022 ROW_RST: issue one row_rst pulse, then ROW_SEEK.
REQ-023 ROW_SEEK: issue exactly win_row0 row_inc pulses, zero pulses if win_row0==0, then COL_RST.
REQ-024 COL_RST: issue one col_rst pulse; COL_SEEK: issue win_col0 col_inc pulses, then SETTLE.
REQ-025 newline_sample pulses on the first SETTLE cycle of each row, when col_index==0.
REQ-026 SETTLE: wait settle_counts cycles, none if 0, then CAPTURE.
REQ-027 CAPTURE: adc_capture_start high for exactly one cycle, then WAIT_DONE.
REQ-028 WAIT_DONE: on adc_capture_done, go to NEXT.
REQ-029 WAIT_DONE timeout: if adc_capture_done has not arrived after DONE_TIMEOUT cycles, pulse capture_timeout and go to IDLE with no frame_done.
REQ-030 NEXT, if col_index<win_cols-1: col_index++, one col_inc pulse, SETTLE.
REQ-031 NEXT, else if row_index<win_rows-1: row_index++, col_index=0, one row_inc pulse, COL_RST.
REQ-032 NEXT, otherwise: frame_done pulses one cycle, then IDLE.
REQ-033 frame_start while busy is ignored and not queued.
REQ-034 abort while busy: IDLE on the next edge; all pulse outputs low that cycle; no frame_done; abort has priority over any transition.
REQ-035 adc_capture_done outside WAIT_DONE is ignored.
REQ-036 Counters are 8 bits and are always compared against latched bounds, so no wrap-around can occur with a valid config.

Reset
REQ-037 Reset holds state IDLE; all outputs 0; row_index=col_index=0; latched config=0; timers=0.
REQ-038 Reset has priority over abort and frame_start, and mid-scan reset discards the scan without frame_done.

Verification
REQ-039 Window win_row0=2, win_col0=3, win_rows=2, win_cols=2, settle_counts=5, done returned 20 cycles after start -> 1 row_rst, 3 row_inc, 2 col_rst, 3+1 col_inc per row, 4 adc_capture_start, 2 newline_sample, 1 frame_done.
REQ-040 win_cols=0, or win_col0=100 with win_cols=20 -> cfg_error pulse; busy stays 0; no pointer pulses.
REQ-041 1x1 window at origin, settle_counts=0 -> row_rst, col_rst, then adc_capture_start on the cycle after the col_rst low phase ends; frame_done after done.
REQ-042 adc_capture_done withheld -> capture_timeout exactly DONE_TIMEOUT cycles after entering WAIT_DONE; busy drops; no frame_done.
REQ-043 abort asserted during a col_inc high phase -> col_inc low the next cycle, busy=0, no frame_done; a following frame_start starts a fresh scan from row_rst.
REQ-044 frame_start pulsed while busy, and reset asserted mid-frame -> the extra request is ignored; reset returns all outputs to 0 within one cycle.
